// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stage-hold vectors,
// the ERET exception code, control-level constants and the FSM state type.
package pipe_stall_ctrl_pkg;

    localparam logic        STOP       = 1'b1;
    localparam logic        NOSTOP     = 1'b0;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Hold vectors, bit 0 = pc ... bit 5 = wb; each freezes its stage and all earlier ones.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALLED = 2'd1,
        ST_FLUSHED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of stall requests, exception inputs and control outputs between the
// pipeline stages (master) and pipe_stall_ctrl (slave).
interface pipe_stall_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_timeout, perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_timeout, perf_stall_cycles, perf_flush_count
    );
endinterface

// File: rtl/pipe_stall_ctrl_stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag; a flush or reset
// clears both, and the counter saturates instead of wrapping.
module stall_watchdog
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall_any,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_stall_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(STALL_TIMEOUT - 1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_stall_timeout;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            if (i_flush || !i_stall_any) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            // Flush takes precedence over a coincident set condition.
            if (i_flush) begin
                r_stall_timeout <= 1'b0;
            end else if (i_stall_any && r_stall_cnt == TIMEOUT_M1) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign o_stall_cnt     = r_stall_cnt;
    assign o_stall_timeout = r_stall_timeout;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: prioritised stall vector, exception flush with
// redirect PC, stale-exception masking FSM. Perf counters gated by PIPE_CTRL_PERF_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stall_ctrl_if.slave    bus
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic             w_exc_taken;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic [31:0]      w_new_pc;
    logic             w_stall_any;
    logic [CNT_W-1:0] w_stall_cnt;
    logic             w_stall_timeout;

    // The exception seen in the cycle right after a flush is the one just taken.
    assign w_exc_taken = (rst != RST_ENABLE) && (bus.excepttype_i != ZERO_WORD)
                         && (r_state != ST_FLUSHED);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (w_flush) begin
            w_state_nxt = ST_FLUSHED;
        end else if (w_stall != STALL_NONE) begin
            w_state_nxt = ST_STALLED;
        end
    end

    always_comb begin
        w_stall  = STALL_NONE;
        w_flush  = NOSTOP;
        w_new_pc = ZERO_WORD;
        if (rst == RST_ENABLE) begin
            w_stall = STALL_NONE;
        end else if (w_exc_taken) begin
            w_flush  = STOP;
            w_new_pc = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
        end else if (bus.stallreq_from_mem) begin
            w_stall = STALL_MEM;
        end else if (bus.stallreq_from_ex) begin
            w_stall = STALL_EX;
        end else if (bus.stallreq_from_id || bus.stallreq_from_if) begin
            w_stall = STALL_ID;
        end
    end

    assign w_stall_any = (w_stall != STALL_NONE);

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_wd (
        .clk             (clk),
        .rst             (rst),
        .i_stall_any     (w_stall_any),
        .i_flush         (w_flush),
        .o_stall_cnt     (w_stall_cnt),
        .o_stall_timeout (w_stall_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_flush_count;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_perf_stall_cycles <= ZERO_WORD;
            r_perf_flush_count  <= ZERO_WORD;
        end else begin
            if (w_stall_any) r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            if (w_flush)     r_perf_flush_count  <= r_perf_flush_count + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = r_perf_stall_cycles;
    assign bus.perf_flush_count  = r_perf_flush_count;
`else
    assign bus.perf_stall_cycles = ZERO_WORD;
    assign bus.perf_flush_count  = ZERO_WORD;
`endif

    assign bus.stall         = w_stall;
    assign bus.flush         = w_flush;
    assign bus.new_pc        = w_new_pc;
    assign bus.stall_timeout = w_stall_timeout;

endmodule
